add_tree_pipe: RTL and testbench

ADD_TREE_PIPE -- requirements
Module: add_tree_pipe

---
 rtl/add_tree_pipe.sv | 95 +++++++++
 tb/tb_add_tree_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_tree_pipe.sv
// Pipelined unsigned adder tree: one input register stage, then log2(N) pairwise adder stages.
// Optional output saturation to W bits with overflow flag when ADD_TREE_SAT_EN is defined.
module add_tree_pipe #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N*W-1:0]              in_data,
  input  logic                        in_valid,
  input  logic                        in_mode,
  output logic                        in_ready,
`ifdef ADD_TREE_SAT_EN
  output logic [W-1:0]                out_data,
`else
  output logic [W+$clog2(N)-1:0]      out_data,
`endif
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef ADD_TREE_SAT_EN
  ,
  output logic                        out_ovf
`endif
);

  localparam int S  = $clog2(N);
  localparam int OW = W + S;

  logic           adv;
  logic [S:0]     vld_q;
  logic [N*W-1:0] in_q;
  logic [N*W-1:0] in_masked;
  logic [OW-1:0]  tree_sum;

  // The whole pipeline moves together; it only freezes when a finished beat is refused.
  assign adv      = !vld_q[S] || out_ready;
  assign in_ready = adv;

  // Pass-through mode zeroes operands 1..N-1, so the tree itself yields operand 0 unchanged.
  assign in_masked = in_mode ? {{((N-1)*W){1'b0}}, in_data[W-1:0]} : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      in_q  <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[S-1:0], in_valid};
      in_q  <= in_masked;
    end
  end

  for (genvar gi = 1; gi <= S; gi++) begin : g_stage
    localparam int CW  = W + gi;
    localparam int PW  = CW - 1;
    localparam int CNT = N >> gi;

    logic [2*CNT*PW-1:0] prev;
    logic [CNT*CW-1:0]   sum_d;
    logic [CNT*CW-1:0]   sum_q;

    if (gi == 1) begin : g_first
      assign prev = in_q;
    end else begin : g_next
      assign prev = g_stage[gi-1].sum_q;
    end

    always_comb begin
      sum_d = '0;
      for (int k = 0; k < CNT; k++) begin
        sum_d[k*CW +: CW] = CW'(prev[2*k*PW +: PW]) + CW'(prev[(2*k+1)*PW +: PW]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
      end else if (adv) begin
        sum_q <= sum_d;
      end
    end
  end

  assign tree_sum  = g_stage[S].sum_q;
  assign out_valid = vld_q[S];

`ifdef ADD_TREE_SAT_EN
  logic clamp;
  assign clamp    = |tree_sum[OW-1:W];
  assign out_data = clamp ? {W{1'b1}} : tree_sum[W-1:0];
  assign out_ovf  = vld_q[S] && clamp;
`else
  assign out_data = tree_sum;
`endif

endmodule

// File: tb/tb_add_tree_pipe.sv
// Scoreboard bench for add_tree_pipe: main W=8,N=4 instance plus W=4 sweeps at N=2 and N=8.
// Builds with or without ADD_TREE_SAT_EN.
module tb_add_tree_pipe;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;
`ifdef ADD_TREE_SAT_EN
  localparam int OUTW = W;
`else
  localparam int OUTW = W + S;
`endif

  typedef struct {
    int data;
    bit clip;
    int cyc;
    bit chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0]  in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_mode = 1'b0;
  logic            in_ready;
  logic [OUTW-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
`ifdef ADD_TREE_SAT_EN
  logic            out_ovf;
`endif

  exp_t            sb[$];
  exp_t            mon_e;
  int              n_tests = 0;
  int              n_fail = 0;
  int              cycle = 0;
  int              rdy_mode = 0;
  int              pat_i = 0;
  bit              held = 1'b0;
  logic [OUTW-1:0] held_data = '0;
  bit              sweep_done [2];

  add_tree_pipe #(.W(W), .N(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_mode(in_mode), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ADD_TREE_SAT_EN
    , .out_ovf(out_ovf)
`endif
  );

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic over the operand list.
  function automatic int tree_ref(input logic [31:0] ops, input bit mode, input int n, input int w);
    int s = 0;
    int mask = (1 << w) - 1;
    if (mode) return int'(ops) & mask;
    for (int k = 0; k < n; k++) s += int'(ops >> (k * w)) & mask;
    return s;
  endfunction

  function automatic exp_t make_exp(input int v, input int w, input bit chk);
    exp_t e;
    int maxv = (1 << w) - 1;
    e.data = v;
    e.clip = (v > maxv);
`ifdef ADD_TREE_SAT_EN
    if (e.clip) e.data = maxv;
`endif
    e.cyc = cycle;
    e.chk = chk;
    return e;
  endfunction

  // out_ready patterns: 0 always 1, 1 = 1,0,0,1 repeating, 2 random, 3 always 0
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
          pat_i++;
        end
        2: out_ready = ($urandom % 3) != 0;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops scoreboard on every consumed beat, checks stall stability and ready rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else begin
      check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      if (held) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(held_data));
      end
      if (out_valid && out_ready) begin
        held <= 1'b0;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0d expected no beat", out_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", int'(out_data), mon_e.data);
`ifdef ADD_TREE_SAT_EN
          check("out_ovf", int'(out_ovf), int'(mon_e.clip));
`endif
          if (mon_e.chk) check("latency", cycle - mon_e.cyc, S + 1);
          $display("[TB] main beat out=%0d exp=%0d lat=%0d", out_data, mon_e.data, cycle - mon_e.cyc);
        end
      end else if (out_valid) begin
        held      <= 1'b1;
        held_data <= out_data;
      end else begin
        held <= 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] ops, input bit mode, input bit chk);
    int waited = 0;
    in_data  = ops;
    in_mode  = mode;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(make_exp(tree_ref(ops, mode, N, W), W, chk));
        break;
      end
      waited++;
      if (waited > 500) begin
        check("accept_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", sb.size(), 0);
    #1;
  endtask

  // Sweeps at W=4 with N=2 and N=8, out_ready held high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SN = (gi == 0) ? 2 : 8;
    localparam int SW = 4;
    localparam int SS = $clog2(SN);
`ifdef ADD_TREE_SAT_EN
    localparam int SOW = SW;
`else
    localparam int SOW = SW + SS;
`endif
    logic [SN*SW-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_mode = 1'b0;
    logic             s_ready;
    logic             s_ovld;
    logic [SOW-1:0]   s_out;
`ifdef ADD_TREE_SAT_EN
    logic             s_ovf;
`endif
    exp_t             s_q[$];
    exp_t             s_e;
    logic [31:0]      r;

    add_tree_pipe #(.W(SW), .N(SN)) u_sweep (
      .clk(clk), .rst_n(rst_n),
      .in_data(s_data), .in_valid(s_valid), .in_mode(s_mode), .in_ready(s_ready),
      .out_data(s_out), .out_valid(s_ovld), .out_ready(1'b1)
`ifdef ADD_TREE_SAT_EN
      , .out_ovf(s_ovf)
`endif
    );

    initial begin
      wait (rst_n == 1'b1);
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        r       = $urandom;
        s_data  = r[SN*SW-1:0];
        s_valid = ($urandom % 10) < 7;
        s_mode  = ($urandom % 4) == 0;
        @(negedge clk);
        if (s_valid && s_ready) s_q.push_back(make_exp(tree_ref(r, s_mode, SN, SW), SW, 1'b1));
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      repeat (SS + 4) @(posedge clk);
      check("sweep_drain", s_q.size(), 0);
      sweep_done[gi] = 1'b1;
    end

    always @(negedge clk) begin
      if (rst_n && s_ovld) begin
        if (s_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sweep_unexpected N=%0d: got data %0d expected no beat", SN, s_out);
        end else begin
          s_e = s_q.pop_front();
          check("sweep_data", int'(s_out), s_e.data);
          check("sweep_latency", cycle - s_e.cyc, SS + 1);
          $display("[TB] sweep N=%0d out=%0d exp=%0d", SN, s_out, s_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #12;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_in_ready", int'(in_ready), 1);
`ifdef ADD_TREE_SAT_EN
    check("reset_out_ovf", int'(out_ovf), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(32'h04030201, 1'b0, 1'b1);
    drain();
    issue(32'hFFFFFFFF, 1'b0, 1'b1);
    drain();
    issue(32'h09090907, 1'b1, 1'b1);
    issue(32'h09090907, 1'b0, 1'b1);
    drain();

    rdy_mode = 1;
    pat_i    = 0;
    for (int i = 0; i < 8; i++) issue({24'd0, 8'(i)}, 1'b0, 1'b0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      issue($urandom, ($urandom % 4) == 0, 1'b0);
      if (($urandom % 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    rdy_mode = 0;
    t = 0;
    while (!(sweep_done[0] && sweep_done[1]) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("sweeps_finished", int'(sweep_done[0] && sweep_done[1]), 1);

    // Mid-stream reset with three beats held in the pipe.
    rdy_mode = 3;
    @(posedge clk); #2;
    issue(32'h11111111, 1'b0, 1'b0);
    issue(32'h22222222, 1'b0, 1'b0);
    issue(32'h33333333, 1'b0, 1'b0);
    @(negedge clk);
    check("prereset_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(out_valid), 0);
    check("async_reset_data", int'(out_data), 0);
    check("async_reset_ready", int'(in_ready), 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rdy_mode = 0;
    rst_n    = 1'b1;
    issue(32'h01010101, 1'b0, 1'b1);
    drain();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
